// File: rtl/aes128_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes128_key_expand
// Brief    : Iterative AES-128 key schedule, one round key per clock, 11 keys
//            held in flops behind a registered read port.
// Revision : 1.0
// ============================================================================
module aes128_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data
);

    localparam int NUM_KEYS = NUM_ROUNDS + 1;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [127:0]   work_q,  work_d;
    logic           busy_q,  busy_d;
    logic           valid_q, valid_d;
    logic [127:0]   rd_data_q, rd_data_d;
    logic [127:0]   rk_q [NUM_KEYS];

    logic           w_rk_we;
    logic [3:0]     w_rk_widx;
    logic [127:0]   w_rk_wdata;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_rot, w_sub, w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_next;

    assign {w_w0, w_w1, w_w2, w_w3} = work_q;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = {sbox_f(w_rot[31:24]), sbox_f(w_rot[23:16]),
                    sbox_f(w_rot[15:8]),  sbox_f(w_rot[7:0])};
    assign w_t   = w_sub ^ {rcon_f(round_q), 24'h0};
    assign w_n0  = w_w0 ^ w_t;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            round_q   <= 4'd1;
            work_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            work_q    <= work_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    // A load pulse wins in any state, so a mid-expansion load simply restarts.
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        work_d     = work_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        w_rk_we    = 1'b0;
        w_rk_widx  = round_q;
        w_rk_wdata = w_next;
        if (key_load) begin
            state_d    = ST_EXPAND;
            round_d    = 4'd1;
            work_d     = key_in;
            busy_d     = 1'b1;
            valid_d    = 1'b0;
            w_rk_we    = 1'b1;
            w_rk_widx  = 4'd0;
            w_rk_wdata = key_in;
        end else if (state_q == ST_EXPAND) begin
            w_rk_we = 1'b1;
            work_d  = w_next;
            if (round_q == 4'(NUM_ROUNDS)) begin
                state_d = ST_IDLE;
                round_d = 4'd1;
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_rk
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    rk_q[i] <= '0;
                end else if (w_rk_we && (w_rk_widx == 4'(i))) begin
                    rk_q[i] <= w_rk_wdata;
                end
            end
        end
    endgenerate

    // Indices past the last round key fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rk_rd_idx == 4'(i)) begin
                rd_data_d = rk_q[i];
            end
        end
    end

    assign busy       = busy_q;
    assign keys_valid = valid_q;
    assign rk_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_key_expand
// Brief    : Directed self-checking bench for aes128_key_expand using
//            FIPS-197 reference schedules and a read-port scoreboard.
// Revision : 1.0
// ============================================================================
module tb_aes128_key_expand;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    logic [127:0] exp_a1 [16];
    logic [127:0] exp_zero [16];
    logic [127:0] sb_q [$];
    int           n_checks = 0;
    int           n_pass   = 0;

    aes128_key_expand #(.NUM_ROUNDS(10)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .key_in     (key_in),
        .key_load   (key_load),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse_load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Waits for keys_valid after a load edge; latency must be exactly 10.
    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 9) begin
                chk({tag, "_busy9"}, {127'h0, busy}, 128'h1);
            end
            if (keys_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_busy_done"}, {127'h0, busy}, 128'h0);
    endtask

    // Each index is pushed with its expected value; the output one edge later pops it.
    task automatic sweep(input string tag, input int last, input logic is_a1);
        for (int i = 0; i <= last; i++) begin
            rk_rd_idx = 4'(i);
            sb_q.push_back(is_a1 ? exp_a1[i] : exp_zero[i]);
            tick();
            chk($sformatf("%s_rk%0d", tag, i), rk_rd_data, sb_q.pop_front());
        end
    endtask

    task automatic read_one(input string tag, input int idx, input logic [127:0] exp);
        rk_rd_idx = 4'(idx);
        sb_q.push_back(exp);
        tick();
        chk(tag, rk_rd_data, sb_q.pop_front());
    endtask

    initial begin
        exp_a1[0]  = KEY_A1;
        exp_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 16; i++) exp_zero[i] = '0;
        for (int i = 11; i < 16; i++) exp_a1[i] = '0;

        ARESET    = 1'b1;
        key_in    = '0;
        key_load  = 1'b0;
        rk_rd_idx = 4'd0;
        tick();
        tick();
        chk("rst_busy",  {127'h0, busy},       128'h0);
        chk("rst_valid", {127'h0, keys_valid}, 128'h0);
        chk("rst_data",  rk_rd_data,           128'h0);
        ARESET = 1'b0;
        tick();

        // FIPS-197 A.1 key, then full read sweep including out-of-range indices
        pulse_load(KEY_A1);
        chk("a1_busy_e0",  {127'h0, busy},       128'h1);
        chk("a1_valid_e0", {127'h0, keys_valid}, 128'h0);
        wait_valid("a1");
        sweep("a1", 15, 1'b1);

        // Reload while valid with the all-zero key
        pulse_load(128'h0);
        chk("reload_valid_drop", {127'h0, keys_valid}, 128'h0);
        chk("reload_busy",       {127'h0, busy},       128'h1);
        wait_valid("reload");
        read_one("zero_rk0",  0,  128'h0);
        read_one("zero_rk1",  1,  128'h62636363626363636263636362636363);
        read_one("zero_rk10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_one("zero_rk11", 11, 128'h0);

        // Restart mid-expansion: zero key, then A.1 key four cycles later
        pulse_load(128'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("restart_gap%0d_valid", n), {127'h0, keys_valid}, 128'h0);
        end
        pulse_load(KEY_A1);
        chk("restart_valid_e0", {127'h0, keys_valid}, 128'h0);
        wait_valid("restart");
        sweep("restart", 10, 1'b1);

        // Back-to-back pulses: only the final key counts
        key_in   = 128'h0;
        key_load = 1'b1;
        tick();
        pulse_load(KEY_A1);
        wait_valid("b2b");
        read_one("b2b_rk1",  1,  exp_a1[1]);
        read_one("b2b_rk10", 10, exp_a1[10]);

        // Reset five cycles into an expansion
        pulse_load(128'h0);
        for (int n = 0; n < 5; n++) tick();
        ARESET    = 1'b1;
        rk_rd_idx = 4'd1;
        tick();
        chk("midrst_busy",  {127'h0, busy},       128'h0);
        chk("midrst_valid", {127'h0, keys_valid}, 128'h0);
        chk("midrst_data",  rk_rd_data,           128'h0);
        ARESET = 1'b0;
        sweep("midrst", 10, 1'b0);
        tick();
        chk("midrst_idle_busy", {127'h0, busy}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
